// File: rtl/uart_burst_tx_pkg.sv
// Shared definitions for the burst UART transmitter:
// state encodings, speed codes and the gap-length lookup.
package uart_burst_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    localparam logic [7:0] SPD_0MS  = 8'h00;
    localparam logic [7:0] SPD_5MS  = 8'h05;
    localparam logic [7:0] SPD_10MS = 8'h10;
    localparam logic [7:0] SPD_20MS = 8'h20;

    localparam logic [4:0] GAP_MS_0  = 5'd0;
    localparam logic [4:0] GAP_MS_5  = 5'd5;
    localparam logic [4:0] GAP_MS_10 = 5'd10;
    localparam logic [4:0] GAP_MS_20 = 5'd20;

    // Unknown speed codes fall back to no gap.
    function automatic logic [4:0] gap_ms(input logic [7:0] code);
        case (code)
            SPD_5MS:  gap_ms = GAP_MS_5;
            SPD_10MS: gap_ms = GAP_MS_10;
            SPD_20MS: gap_ms = GAP_MS_20;
            default:  gap_ms = GAP_MS_0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter shared by bit periods and inter-frame gaps.
// Loading N gives an expire pulse N+1 cycles later (in the cycle the count is 0).
module uart_bit_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expire
);

    logic [W-1:0] r_count;
    logic         r_active;

    // Count down from the loaded value; a reload always wins over expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (load) begin
            r_count  <= load_value;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == '0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - W'(1);
            end
        end
    end

    assign expire = r_active && (r_count == '0);

endmodule

// File: rtl/uart_burst_tx.sv
// Burst UART transmitter: sends the latched byte byte_count times as 8N1
// frames with an optional millisecond gap between frames.
// Handshake: start is a single-cycle request, accepted only in IDLE;
// done is a single-cycle completion strobe; there is no back-pressure.
module uart_burst_tx
    import uart_burst_tx_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200,
    parameter int MS_TICKS = CLK_FREQ / 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic [7:0] speed_bcd,
    input  logic [7:0] byte_count,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] bytes_sent,
    output logic [2:0] dbg_state
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int GAP_MAX      = 20 * MS_TICKS;
    localparam int TW           = $clog2(((GAP_MAX > CLKS_PER_BIT) ? GAP_MAX : CLKS_PER_BIT) + 1);
    localparam logic [TW-1:0] BIT_LOAD = TW'(CLKS_PER_BIT - 1);

    state_t        r_state, w_state;
    logic [7:0]    r_data, w_data;
    logic [7:0]    r_count, w_count;
    logic [TW-1:0] r_gap, w_gap;
    logic [2:0]    r_bit_idx, w_bit_idx;
    logic [7:0]    r_bytes_sent, w_bytes_sent;
    logic          r_tx, w_tx;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          w_load;
    logic [TW-1:0] w_load_value;
    logic          w_expire;
    logic [7:0]    w_sent_inc;
    logic [TW-1:0] w_gap_cycles;

    assign w_gap_cycles = TW'(gap_ms(speed_bcd)) * TW'(MS_TICKS);

    uart_bit_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_value (w_load_value),
        .expire     (w_expire)
    );

    // State and output registers; outputs are registered copies of next-state values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_data       <= '0;
            r_count      <= '0;
            r_gap        <= '0;
            r_bit_idx    <= '0;
            r_bytes_sent <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_data       <= w_data;
            r_count      <= w_count;
            r_gap        <= w_gap;
            r_bit_idx    <= w_bit_idx;
            r_bytes_sent <= w_bytes_sent;
            r_tx         <= w_tx;
            r_busy       <= w_busy;
            r_done       <= w_done;
        end
    end

    // Next-state logic, timer reloads and the values the outputs take next cycle.
    always_comb begin
        w_state      = r_state;
        w_data       = r_data;
        w_count      = r_count;
        w_gap        = r_gap;
        w_bit_idx    = r_bit_idx;
        w_bytes_sent = r_bytes_sent;
        w_load       = 1'b0;
        w_load_value = BIT_LOAD;
        w_sent_inc   = (r_bytes_sent == 8'hFF) ? 8'hFF : r_bytes_sent + 8'd1;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_data       = data;
                    w_count      = byte_count;
                    w_gap        = w_gap_cycles;
                    w_bytes_sent = '0;
                    if (byte_count == 8'h00) begin
                        w_state = ST_FINISH;
                    end else begin
                        w_state = ST_START;
                        w_load  = 1'b1;
                    end
                end
            end
            ST_START: begin
                if (w_expire) begin
                    w_state   = ST_DATA;
                    w_bit_idx = '0;
                    w_load    = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state = ST_STOP;
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_expire) begin
                    w_bytes_sent = w_sent_inc;
                    if (w_sent_inc == r_count) begin
                        w_state = ST_FINISH;
                    end else if (r_gap != '0) begin
                        w_state      = ST_GAP;
                        w_load       = 1'b1;
                        w_load_value = r_gap - TW'(1);
                    end else begin
                        w_state = ST_START;
                        w_load  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_expire) begin
                    w_state = ST_START;
                    w_load  = 1'b1;
                end
            end
            ST_FINISH: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_tx = 1'b1;
        case (w_state)
            ST_START: w_tx = 1'b0;
            ST_DATA:  w_tx = w_data[w_bit_idx];
            default:  w_tx = 1'b1;
        endcase
        w_busy = (w_state == ST_START) || (w_state == ST_DATA) ||
                 (w_state == ST_STOP)  || (w_state == ST_GAP);
        w_done = (w_state == ST_FINISH);
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign bytes_sent = r_bytes_sent;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_burst_tx.sv
// Self-checking bench for uart_burst_tx using a frame-level reference model.
module tb_uart_burst_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data;
    logic [7:0] speed_bcd;
    logic [7:0] byte_count;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] bytes_sent;
    logic [2:0] dbg_state;

    int n_checks;
    int n_fail;

    logic [0:0] exp_q[$];

    uart_burst_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000),
        .MS_TICKS (1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data       (data),
        .speed_bcd  (speed_bcd),
        .byte_count (byte_count),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .bytes_sent (bytes_sent),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gap length in ms from the speed code
    function automatic int model_gap_ms(input logic [7:0] s);
        if (s == 8'h05) return 5;
        if (s == 8'h10) return 10;
        if (s == 8'h20) return 20;
        return 0;
    endfunction

    // Build the expected per-cycle tx waveform of a whole burst
    task automatic build_model(input logic [7:0] d, input logic [7:0] n, input logic [7:0] spd);
        int gap;
        logic [0:0] b;
        gap = model_gap_ms(spd) * 1000;
        exp_q.delete();
        for (int f = 0; f < int'(n); f++) begin
            for (int k = 0; k < 10; k++) begin
                if (k == 0) b = 1'b0;
                else if (k == 9) b = 1'b1;
                else b = d[k-1];
                repeat (10) exp_q.push_back(b);
            end
            if (f < int'(n) - 1) repeat (gap) exp_q.push_back(1'b1);
        end
    endtask

    // Start a burst at the current (negedge) cycle and check it to completion.
    task automatic run_burst(input logic [7:0] d, input logic [7:0] n, input logic [7:0] spd,
                             input int poke_at, input bit finish_start, input string name);
        int tx_err, busy_err, done_err, first_bad;
        build_model(d, n, spd);
        tx_err = 0; busy_err = 0; done_err = 0; first_bad = -1;
        start = 1'b1; data = d; byte_count = n; speed_bcd = spd;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (tx !== exp_q[i]) begin
                tx_err++;
                if (first_bad < 0) first_bad = i;
            end
            if (busy !== 1'b1) busy_err++;
            if (done !== 1'b0) done_err++;
            if (i == poke_at) begin
                start = 1'b1;
                data  = 8'h00;
            end
            @(negedge clk);
            if (i == poke_at) start = 1'b0;
        end
        n_checks++;
        if (tx_err != 0) begin
            n_fail++;
            $display("FAIL %s tx_wave: %0d mismatching cycles (first at k+%0d), required 0", name, tx_err, first_bad + 1);
        end
        n_checks++;
        if (busy_err != 0) begin
            n_fail++;
            $display("FAIL %s busy_wave: busy low in %0d cycles, required 0", name, busy_err);
        end
        n_checks++;
        if (done_err != 0) begin
            n_fail++;
            $display("FAIL %s early_done: done high in %0d cycles, required 0", name, done_err);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s finish_cycle: done=%b busy=%b tx=%b, required 1 0 1", name, done, busy, tx);
        end
        n_checks++;
        if (bytes_sent !== n) begin
            n_fail++;
            $display("FAIL %s bytes_sent: got %0h, required %0h", name, bytes_sent, n);
        end
        if (finish_start) begin
            start = 1'b1; data = 8'h3C; byte_count = 8'h01; speed_bcd = 8'h00;
        end else begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
                n_fail++;
                $display("FAIL %s after_done: done=%b busy=%b tx=%b, required 0 0 1", name, done, busy, tx);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; data = 8'h00; speed_bcd = 8'h00; byte_count = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bytes_sent !== 8'h00 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b bytes_sent=%0h state=%0d, required 1 0 0 0 0",
                     tx, busy, done, bytes_sent, dbg_state);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_line();
        int bad;
        bad = 0;
        data = 8'h00; byte_count = 8'h05;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_line: %0d cycles not idle, required 0", bad);
        end
    endtask

    task automatic test_single_frame();
        run_burst(8'hA5, 8'h01, 8'h00, -1, 1'b0, "single");
    endtask

    task automatic test_start_while_busy();
        run_burst(8'hA5, 8'h01, 8'h00, 49, 1'b0, "start_busy");
    endtask

    task automatic test_back_to_back();
        run_burst(8'($urandom_range(0, 255)), 8'h20, 8'h00, -1, 1'b0, "back_to_back");
    endtask

    task automatic test_gap();
        run_burst(8'h5A, 8'h02, 8'h05, -1, 1'b0, "gap5");
        run_burst(8'hC3, 8'h02, 8'h10, -1, 1'b0, "gap10");
        run_burst(8'h81, 8'h02, 8'h20, -1, 1'b0, "gap20");
    endtask

    task automatic test_zero_count();
        run_burst(8'h77, 8'h00, 8'h00, -1, 1'b1, "zero");
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL finish_start_ignored: busy=%b tx=%b done=%b state=%0d, required 0 1 0 0",
                     busy, tx, done, dbg_state);
        end
        run_burst(8'h96, 8'h01, 8'h05, -1, 1'b0, "idle_start");
    endtask

    task automatic test_reset_mid_frame();
        start = 1'b1; data = 8'h00; byte_count = 8'h02; speed_bcd = 8'h00;
        @(negedge clk);
        start = 1'b0;
        repeat (134) @(negedge clk);
        n_checks++;
        if (tx !== 1'b0 || busy !== 1'b1 || bytes_sent !== 8'h01) begin
            n_fail++;
            $display("FAIL pre_reset: tx=%b busy=%b bytes_sent=%0h, required 0 1 01", tx, busy, bytes_sent);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || bytes_sent !== 8'h00 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: tx=%b busy=%b bytes_sent=%0h state=%0d, required 1 0 00 0",
                     tx, busy, bytes_sent, dbg_state);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_burst(8'h5A, 8'h01, 8'h00, -1, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        logic [7:0] codes[5];
        codes[0] = 8'h00; codes[1] = 8'h01; codes[2] = 8'h15; codes[3] = 8'h99; codes[4] = 8'h50;
        for (int r = 0; r < 4; r++) begin
            run_burst(8'($urandom_range(0, 255)), 8'($urandom_range(1, 4)),
                      codes[$urandom_range(0, 4)], -1, 1'b0, "random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_idle_line();
        test_single_frame();
        test_start_while_busy();
        test_back_to_back();
        test_gap();
        test_zero_count();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
